// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns held whole-line read/write requests into 4-beat 64-bit memory bursts
// and reassembles read beats into a line buffer that persists until the next read.
module cacheline_adaptor #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_beat   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_address,
    input  logic [s_line-1:0] line_wdata,
    output logic              line_resp,
    output logic [s_line-1:0] line_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [s_beat-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [s_beat-1:0] mem_rdata
);
    localparam int n_beats = s_line / s_beat;
    localparam int cw = $clog2(n_beats);
    localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            r_state;
    logic [cw-1:0]     r_cnt;
    logic [31:0]       r_addr;
    logic [s_line-1:0] r_rbuf;
    logic [s_line-1:0] r_wbuf;
    logic              w_last;

    assign w_last = r_cnt == cw'(n_beats - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rbuf  <= '0;
            r_wbuf  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (line_write || line_read) begin
                        r_addr <= line_address & addr_mask;
                        r_cnt  <= '0;
                    end
                    // write takes priority if both requests are raised together
                    if (line_write) begin
                        r_wbuf  <= line_wdata;
                        r_state <= WRITE;
                    end else if (line_read) begin
                        r_state <= READ;
                    end
                end
                READ: if (mem_resp) begin
                    r_rbuf[int'(r_cnt)*s_beat +: s_beat] <= mem_rdata;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= DONE;
                end
                WRITE: if (mem_resp) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_read    = r_state == READ;
    assign mem_write   = r_state == WRITE;
    assign line_resp   = r_state == DONE;
    assign line_rdata  = r_rbuf;
    assign mem_address = (mem_read || mem_write) ? r_addr : '0;
    assign mem_wdata   = mem_write ? r_wbuf[int'(r_cnt)*s_beat +: s_beat] : '0;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: scoreboard bench with a line-level memory model and a beat-level memory responder.
module tb_cacheline_adaptor;
    logic         clk = 1'b0;
    logic         rst;
    logic         line_read, line_write, line_resp;
    logic [31:0]  line_address;
    logic [255:0] line_wdata, line_rdata;
    logic         mem_read, mem_write, mem_resp;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst),
        .line_read(line_read), .line_write(line_write),
        .line_address(line_address), .line_wdata(line_wdata),
        .line_resp(line_resp), .line_rdata(line_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] phys[logic [31:0]];
    logic [255:0] ref_mem[logic [31:0]];
    int           n_cmp = 0;
    int           n_err = 0;
    int           mode = 1;
    logic [31:0]  script = '0;
    bit           idle_noise = 1'b1;

    function automatic logic [255:0] init_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = (a * 32'd7) ^ (32'h0101_0101 * i) ^ 32'hC3C3_0000;
        return l;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [255:0] phys_get(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : init_line(a);
    endfunction

    function automatic logic [255:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [255:0] l);
        phys[a] = l;
        ref_mem[a] = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        line_read = 1'b0;
        line_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    // Issue one line request, hold it until line_resp, drop it the next cycle.
    task automatic xfer(input bit wr, input bit rd, input logic [31:0] a, input logic [255:0] d,
                        output int lat, output int st);
        exp_t e;
        int   n;
        n = 0;
        e.wr = wr;
        e.addr = a & 32'hFFFF_FFE0;
        if (wr) ref_mem[e.addr] = d;
        e.data = wr ? d : ref_get(e.addr);
        sb.push_back(e);
        line_write = wr;
        line_read = rd;
        line_address = a;
        line_wdata = d;
        lat = -1;
        st = -1;
        forever begin
            @(negedge clk);
            if (st < 0 && (mem_read || mem_write)) st = n;
            if (line_resp) begin
                lat = n;
                break;
            end
            if (n >= 1 && $urandom_range(0, 3) == 0) begin
                line_address = $urandom;
                line_wdata = rand_line();
            end
            n++;
            if (n > 400) begin
                n_cmp++;
                n_err++;
                $display("FAIL xfer_timeout: got no line_resp expected one within 400 cycles");
                break;
            end
        end
        @(posedge clk);
        #1 line_read = 1'b0;
        line_write = 1'b0;
        if (lat < 0) do_reset();
    endtask

    // Physical memory: serves/stores beats in burst order at the presented address.
    initial begin
        int           bidx;
        int           cyc;
        logic [255:0] l;
        bit           go;
        bidx = 0;
        cyc = 0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rdata = {$urandom, $urandom};
            if (mem_read || mem_write) begin
                cyc++;
                go = mode == 0 ? ($urandom_range(0, 99) < 60) : mode == 1 ? 1'b1 : (cyc < 32 && script[cyc]);
                mem_resp = go;
                if (go) begin
                    l = phys_get(mem_address);
                    if (mem_read) mem_rdata = l[bidx*64 +: 64];
                    else begin
                        l[bidx*64 +: 64] = mem_wdata;
                        phys[mem_address] = l;
                    end
                    bidx = (bidx + 1) % 4;
                end
            end else begin
                cyc = 0;
                bidx = 0;
                mem_resp = idle_noise && $urandom_range(0, 2) == 0;
            end
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each line_resp.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                continue;
            end
            chk("rw_exclusive", mem_read && mem_write, 0);
            if (mem_read || mem_write) begin
                if (sb.size() == 0) chk("burst_unexpected", 1, 0);
                else begin
                    chk("burst_kind", mem_write, sb[0].wr);
                    chk("burst_addr", mem_address, sb[0].addr);
                end
            end else chk("idle_addr", mem_address, 0);
            if (!mem_write) chk("idle_wdata", mem_wdata, 0);
            chk("resp_pulse", line_resp && prev, 0);
            if (line_resp) begin
                chk("resp_no_burst", mem_read || mem_write, 0);
                if (sb.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    if (e.wr) chk("write_line", phys_get(e.addr), e.data);
                    else chk("read_line", line_rdata, e.data);
                end
            end
            prev = line_resp;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish within 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, st;
        logic [255:0] d;
        exp_t         e;
        rst = 1'b1;
        line_read = 1'b0;
        line_write = 1'b0;
        line_address = '0;
        line_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_line_resp", line_resp, 0);
        chk("rst_line_rdata", line_rdata, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        mode = 1;
        preload(32'h0000_1220, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        xfer(0, 1, 32'h0000_1234, '0, lat, st);
        chk("read_min_latency", lat, 5);
        chk("read_start", st, 1);

        mode = 2;
        script = (32'd1 << 1) | (32'd1 << 3) | (32'd1 << 4) | (32'd1 << 7);
        preload(32'h0000_1240, rand_line());
        xfer(0, 1, 32'h0000_1240, '0, lat, st);
        chk("read_gap_latency", lat, 8);
        chk("read_gap_start", st, 1);

        mode = 1;
        for (int i = 0; i < 4; i++) d[i*64 +: 64] = 64'(i + 1);
        xfer(1, 0, 32'h8000_00FF, d, lat, st);
        chk("write_latency", lat, 5);
        xfer(0, 1, 32'h8000_00E0, '0, lat, st);
        chk("b2b_read_start", st, 1);
        chk("b2b_read_latency", lat, 5);

        mode = 2;
        script = 32'b110;
        preload(32'h2000_0040, rand_line());
        e.wr = 1'b0;
        e.addr = 32'h2000_0040;
        e.data = ref_get(e.addr);
        sb.push_back(e);
        line_read = 1'b1;
        line_address = 32'h2000_0044;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        line_read = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_mid_mem_read", mem_read, 0);
        chk("rst_mid_line_resp", line_resp, 0);
        chk("rst_mid_rdata_cleared", line_rdata, 0);
        @(posedge clk);
        #1 mode = 1;
        xfer(0, 1, 32'h2000_0050, '0, lat, st);
        chk("post_rst_read_latency", lat, 5);

        idle_noise = 1'b1;
        repeat (6) @(posedge clk);
        #1 d = rand_line();
        xfer(1, 1, 32'h3000_0010, d, lat, st);
        chk("both_req_latency", lat, 5);
        xfer(0, 1, 32'h3000_0000, '0, lat, st);
        chk("both_req_readback_latency", lat, 5);

        mode = 0;
        for (int i = 0; i < 40; i++) begin
            int          k;
            logic [31:0] a;
            k = $urandom_range(0, 9);
            a = 32'h1000_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
            xfer(k < 5, k >= 4, a, rand_line(), lat, st);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        chk("queue_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
